// File: rtl/keypad_entry_pkg.sv
// Shared definitions for the keypad entry block.
// Holds the control key codes, FSM and scan-result encodings, and the
// helpers that map a (row, col) position to its key code and that count
// or locate low row bits.
package keypad_entry_pkg;

  localparam logic [3:0] KEY_CLEAR = 4'hC;
  localparam logic [3:0] KEY_ENTER = 4'hF;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SCAN_NONE   = 2'd0,
    SCAN_SINGLE = 2'd1,
    SCAN_MULTI  = 2'd2
  } scan_kind_t;

  // Key label at row r, column c; the code is the hex value of the label.
  function automatic logic [3:0] keymap(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'hE;
      4'hD: code = 4'h0;
      4'hE: code = 4'hF;
      4'hF: code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

  // Number of active-low bits in a row sample (0..4).
  function automatic logic [2:0] count_lows(input logic [3:0] r);
    return {2'b00, ~r[0]} + {2'b00, ~r[1]} + {2'b00, ~r[2]} + {2'b00, ~r[3]};
  endfunction

  // Index of the lowest-numbered low row; only meaningful with one low.
  function automatic logic [1:0] low_row(input logic [3:0] r);
    logic [1:0] idx;
    if (!r[0]) begin
      idx = 2'd0;
    end else if (!r[1]) begin
      idx = 2'd1;
    end else if (!r[2]) begin
      idx = 2'd2;
    end else begin
      idx = 2'd3;
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Column scanner for a 4x4 active-low keypad.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   rows        : raw row inputs (asynchronous, active-low)
//   cols        : registered column drive, one bit low
//   scan_end    : high in the cycle whose edge takes the column-3 sample
//   scan_kind   : NONE / SINGLE / MULTI for the scan ending this cycle
//   scan_code   : key code when scan_kind is SINGLE
// scan_* are combinational so the consumer acts on the same edge that
// takes the final sample.
module keypad_scanner
  import keypad_entry_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic       scan_end,
  output scan_kind_t scan_kind,
  output logic [3:0] scan_code
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);

  logic [3:0]    sync1_r, sync2_r;
  logic [DW-1:0] dwell_r;
  logic [1:0]    col_r;
  logic [3:0]    cols_r;
  logic [1:0]    lows_acc_r;   // saturates at 2: anything beyond is MULTI
  logic [3:0]    code_acc_r;

  logic          dwell_done_s;
  logic [1:0]    next_col_s;
  logic [2:0]    col_lows_s;
  logic [2:0]    sum_s;
  logic [1:0]    lows_sat_s;
  logic [3:0]    code_next_s;

  // Fold the current column's sample into the running scan result.
  always_comb begin
    dwell_done_s = (dwell_r == DWELL_LAST);
    next_col_s   = col_r + 2'd1;
    col_lows_s   = count_lows(sync2_r);
    sum_s        = {1'b0, lows_acc_r} + col_lows_s;
    if (sum_s >= 3'd2) begin
      lows_sat_s = 2'd2;
    end else begin
      lows_sat_s = sum_s[1:0];
    end
    if (col_lows_s == 3'd1) begin
      code_next_s = keymap(low_row(sync2_r), col_r);
    end else begin
      code_next_s = code_acc_r;
    end
    scan_end  = dwell_done_s && (col_r == 2'd3);
    scan_code = code_next_s;
    case (lows_sat_s)
      2'd0:    scan_kind = SCAN_NONE;
      2'd1:    scan_kind = SCAN_SINGLE;
      default: scan_kind = SCAN_MULTI;
    endcase
  end

  // Row synchronizer, dwell counter, column drive and scan accumulator.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_r    <= 4'b1111;
      sync2_r    <= 4'b1111;
      dwell_r    <= {DW{1'b0}};
      col_r      <= 2'd0;
      cols_r     <= 4'b1110;
      lows_acc_r <= 2'd0;
      code_acc_r <= 4'd0;
    end else begin
      sync1_r <= rows;
      sync2_r <= sync1_r;
      if (dwell_done_s) begin
        dwell_r <= {DW{1'b0}};
        col_r   <= next_col_s;
        cols_r  <= ~(4'b0001 << next_col_s);
        if (col_r == 2'd3) begin
          lows_acc_r <= 2'd0;
          code_acc_r <= 4'd0;
        end else begin
          lows_acc_r <= lows_sat_s;
          code_acc_r <= code_next_s;
        end
      end else begin
        dwell_r <= dwell_r + DW'(1);
      end
    end
  end

  assign cols = cols_r;

endmodule

// File: rtl/keypad_entry.sv
// Keypad entry: debounced single-key decode feeding a two-digit BCD entry.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   rows / cols : keypad matrix (rows in, columns driven low one at a time)
//   tens, ones  : BCD entry digits
//   key_code    : code of the last accepted key
//   key_valid   : one-cycle pulse per accepted press
//   entry_done  : one-cycle pulse when the enter key (F) is accepted
module keypad_entry
  import keypad_entry_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       entry_done
);

  localparam logic [3:0] DEB_LAST = 4'(DEBOUNCE_SCANS);

  logic       scan_end_s;
  scan_kind_t scan_kind_s;
  logic [3:0] scan_code_s;

  state_t     state_r, state_n;
  logic [3:0] cand_r, cand_n;
  logic [3:0] cnt_r, cnt_n;
  logic [3:0] rcnt_r, rcnt_n;
  logic       accept_s;
  logic [3:0] tens_r, tens_n;
  logic [3:0] ones_r, ones_n;
  logic [3:0] key_code_r, key_code_n;
  logic       key_valid_r, key_valid_n;
  logic       entry_done_r, entry_done_n;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV)) u_scanner (
    .clk       (clk),
    .rst_n     (rst_n),
    .rows      (rows),
    .cols      (cols),
    .scan_end  (scan_end_s),
    .scan_kind (scan_kind_s),
    .scan_code (scan_code_s)
  );

  // Press/release debounce FSM, advanced only at scan end.
  always_comb begin
    state_n  = state_r;
    cand_n   = cand_r;
    cnt_n    = cnt_r;
    rcnt_n   = rcnt_r;
    accept_s = 1'b0;
    if (scan_end_s) begin
      case (state_r)
        IDLE: begin
          if (scan_kind_s == SCAN_SINGLE) begin
            cand_n = scan_code_s;
            cnt_n  = 4'd1;
            rcnt_n = 4'd0;
            if (DEB_LAST == 4'd1) begin
              accept_s = 1'b1;
              state_n  = HELD;
            end else begin
              state_n = DEBOUNCE;
            end
          end else begin
            state_n = IDLE;
          end
        end
        DEBOUNCE: begin
          if ((scan_kind_s == SCAN_SINGLE) && (scan_code_s == cand_r)) begin
            cnt_n = cnt_r + 4'd1;
            if (cnt_n == DEB_LAST) begin
              accept_s = 1'b1;
              state_n  = HELD;
              rcnt_n   = 4'd0;
            end else begin
              state_n = DEBOUNCE;
            end
          end else begin
            state_n = IDLE;
            cnt_n   = 4'd0;
          end
        end
        HELD: begin
          // Any key activity restarts the release count; no auto-repeat.
          if (scan_kind_s == SCAN_NONE) begin
            rcnt_n = rcnt_r + 4'd1;
            if (rcnt_n == DEB_LAST) begin
              state_n = IDLE;
              rcnt_n  = 4'd0;
              cnt_n   = 4'd0;
            end else begin
              state_n = HELD;
            end
          end else begin
            rcnt_n = 4'd0;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = 4'd0;
          rcnt_n  = 4'd0;
        end
      endcase
    end else begin
      state_n = state_r;
    end
  end

  // Accept action: digit shift, clear, enter and the output pulses.
  always_comb begin
    tens_n       = tens_r;
    ones_n       = ones_r;
    key_code_n   = key_code_r;
    key_valid_n  = 1'b0;
    entry_done_n = 1'b0;
    if (accept_s) begin
      key_valid_n = 1'b1;
      key_code_n  = cand_n;
      if (cand_n <= 4'd9) begin
        tens_n = ones_r;
        ones_n = cand_n;
      end else if (cand_n == KEY_CLEAR) begin
        tens_n = 4'd0;
        ones_n = 4'd0;
      end else if (cand_n == KEY_ENTER) begin
        entry_done_n = 1'b1;
      end else begin
        tens_n = tens_r;
        ones_n = ones_r;
      end
    end else begin
      key_valid_n = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      cand_r       <= 4'd0;
      cnt_r        <= 4'd0;
      rcnt_r       <= 4'd0;
      tens_r       <= 4'd0;
      ones_r       <= 4'd0;
      key_code_r   <= 4'd0;
      key_valid_r  <= 1'b0;
      entry_done_r <= 1'b0;
    end else begin
      state_r      <= state_n;
      cand_r       <= cand_n;
      cnt_r        <= cnt_n;
      rcnt_r       <= rcnt_n;
      tens_r       <= tens_n;
      ones_r       <= ones_n;
      key_code_r   <= key_code_n;
      key_valid_r  <= key_valid_n;
      entry_done_r <= entry_done_n;
    end
  end

  assign tens       = tens_r;
  assign ones       = ones_r;
  assign key_code   = key_code_r;
  assign key_valid  = key_valid_r;
  assign entry_done = entry_done_r;

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry with SCAN_DIV=4, DEBOUNCE_SCANS=3
// (one full scan = 16 cycles). A pressed key pulls its row low whenever
// its column is driven low.
module tb_keypad_entry;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] tens, ones, key_code;
  logic       key_valid, entry_done;

  logic [15:0] press_m = 16'h0000;  // bit r*4+c set = key at row r, col c held

  int n_checks = 0;
  int n_errors = 0;

  int         kv_total = 0;
  int         ed_total = 0;
  logic [3:0] last_code = 4'h0;
  int         dbl_cnt = 0;
  int         bad_bcd = 0;
  logic       prev_pulse = 1'b0;

  keypad_entry #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rows       (rows),
    .cols       (cols),
    .tens       (tens),
    .ones       (ones),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .entry_done (entry_done)
  );

  always #5 clk = ~clk;

  // Keypad matrix model.
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (press_m[r*4+c] && !cols[c]) rows[r] = 1'b0;
      end
    end
  end

  // Pulse monitor sampled away from the active edge.
  always @(negedge clk) begin
    if (key_valid) begin
      kv_total  <= kv_total + 1;
      last_code <= key_code;
    end
    if (entry_done) ed_total <= ed_total + 1;
    if ((key_valid || entry_done) && prev_pulse) dbl_cnt <= dbl_cnt + 1;
    prev_pulse <= key_valid || entry_done;
    if (tens > 4'd9 || ones > 4'd9) bad_bcd <= bad_bcd + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic hold(input int r, input int c, input int press_scans, input int rel_scans);
    press_m = 16'h0000;
    press_m[r*4+c] = 1'b1;
    repeat (press_scans * 16) @(negedge clk);
    press_m = 16'h0000;
    repeat (rel_scans * 16) @(negedge clk);
  endtask

  // Press one key (5 scans), release (4 scans), expect one accept.
  task automatic key_in(input string tag, input int r, input int c, input logic [3:0] code,
                        input logic [3:0] exp_tens, input logic [3:0] exp_ones);
    int kv0;
    kv0 = kv_total;
    hold(r, c, 5, 4);
    chk({tag, "_kv"}, kv_total - kv0, 1);
    chk({tag, "_code"}, last_code, code);
    chk({tag, "_tens"}, tens, exp_tens);
    chk({tag, "_ones"}, ones, exp_ones);
  endtask

  initial begin
    int kv0, ed0;
    logic [3:0] exp_cols;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_cols", cols, 4'b1110);
    chk("rst_tens", tens, 4'd0);
    chk("rst_ones", ones, 4'd0);
    chk("rst_code", key_code, 4'd0);
    chk("rst_kv", key_valid, 1'b0);
    chk("rst_ed", entry_done, 1'b0);

    // Idle column rotation, 4 cycles per column.
    rst_n = 1'b1;
    kv0 = kv_total;
    ed0 = ed_total;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      exp_cols = ~(4'b0001 << (((i + 1) / 4) % 4));
      chk("idle_cols", cols, exp_cols);
    end
    chk("idle_kv", kv_total - kv0, 0);
    chk("idle_ed", ed_total - ed0, 0);
    chk("idle_digits", {tens, ones}, 8'h00);

    // Digit entry.
    key_in("d5", 1, 1, 4'h5, 4'd0, 4'd5);
    key_in("d7", 2, 0, 4'h7, 4'd5, 4'd7);
    key_in("d2", 0, 1, 4'h2, 4'd7, 4'd2);

    // Bounce: too short to accept.
    kv0 = kv_total;
    hold(0, 2, 2, 4);
    chk("bounce_kv", kv_total - kv0, 0);
    chk("bounce_digits", {tens, ones}, 8'h72);

    // Long hold gives one pulse; short release and re-press gives none.
    kv0 = kv_total;
    hold(2, 2, 20, 2);
    chk("hold9_kv", kv_total - kv0, 1);
    chk("hold9_code", last_code, 4'h9);
    chk("hold9_digits", {tens, ones}, 8'h29);
    kv0 = kv_total;
    hold(2, 2, 5, 4);
    chk("repress9_kv", kv_total - kv0, 0);
    chk("repress9_digits", {tens, ones}, 8'h29);

    // Two keys together.
    kv0 = kv_total;
    press_m = 16'h0003;
    repeat (6 * 16) @(negedge clk);
    press_m = 16'h0000;
    repeat (4 * 16) @(negedge clk);
    chk("multi_kv", kv_total - kv0, 0);
    chk("multi_digits", {tens, ones}, 8'h29);

    // Control keys with 42 entered.
    key_in("d4", 1, 0, 4'h4, 4'd9, 4'd4);
    key_in("d2b", 0, 1, 4'h2, 4'd4, 4'd2);
    ed0 = ed_total;
    key_in("keyF", 3, 2, 4'hF, 4'd4, 4'd2);
    chk("keyF_ed", ed_total - ed0, 1);
    ed0 = ed_total;
    key_in("keyC", 2, 3, 4'hC, 4'd0, 4'd0);
    chk("keyC_ed", ed_total - ed0, 0);

    // Reset in the middle of debouncing 8.
    key_in("d6", 1, 2, 4'h6, 4'd0, 4'd6);
    press_m = 16'h0000;
    press_m[2*4+1] = 1'b1;
    repeat (32) @(negedge clk);
    kv0 = kv_total;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_rst_kv", kv_total - kv0, 0);
    chk("mid_rst_digits", {tens, ones}, 8'h00);
    chk("mid_rst_cols", cols, 4'b1110);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_rst_early_kv", kv_total - kv0, 0);
    repeat (16) @(negedge clk);
    chk("post_rst_kv", kv_total - kv0, 1);
    chk("post_rst_code", last_code, 4'h8);
    chk("post_rst_digits", {tens, ones}, 8'h08);
    press_m = 16'h0000;
    repeat (4 * 16) @(negedge clk);

    chk("no_double_pulse", dbl_cnt, 0);
    chk("bcd_range", bad_bcd, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
